// File: rtl/ram_share_pkg.sv
// Shared types and default widths for the RAM sharing controller.
package ram_share_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 3;

  typedef enum logic {S_CLEAR = 1'b0, S_SERVE = 1'b1} state_t;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one grant per cycle, the requester not granted
// most recently wins a contention. Every grant is an accepted transfer, since a
// grant is only ever given to a requester that is currently valid.
module rr_arb2
  import ram_share_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);
  req_id_t r_last;
  logic    w_gnt_a;
  logic    w_gnt_b;

  // Grant decision from the current valids and the last-grant pointer.
  always_comb begin
    w_gnt_a = i_en & i_req_a & (~i_req_b | (r_last == REQ_B));
    w_gnt_b = i_en & i_req_b & (~i_req_a | (r_last == REQ_A));
  end

  // The pointer starts at "B last" so A wins the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_last <= REQ_B;
    else if (w_gnt_a) r_last <= REQ_A;
    else if (w_gnt_b) r_last <= REQ_B;
  end

  assign o_gnt_a = w_gnt_a;
  assign o_gnt_b = w_gnt_b;
endmodule

// File: rtl/ram_share_ctrl.sv
// Single-port RAM sharing controller: clears the array after reset, then
// arbitrates the port between requesters A and B. It returns read data one
// cycle after acceptance, matching the RAM's registered-address read.
module ram_share_ctrl
  import ram_share_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_a_valid,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_b_valid,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_a_ready,
  output logic              o_b_ready,
  output logic              o_a_rsp_valid,
  output logic              o_b_rsp_valid,
  output logic [DATA_W-1:0] o_a_rsp_data,
  output logic [DATA_W-1:0] o_b_rsp_data,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_busy
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam state_t            RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_SERVE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rsp_vld;
  req_id_t           r_rsp_owner;

  logic              w_serve;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_grant_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_wren;
  logic              w_busy;

  // Arbitration is enabled only in serving state and never while reset is held.
  assign w_serve = (r_state == S_SERVE) & i_reset_n;

  rr_arb2 u_arb (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_n),
    .i_en    (w_serve),
    .i_req_a (i_a_valid),
    .i_req_b (i_b_valid),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign w_grant_we = w_gnt_a ? i_a_we : i_b_we;

  // Next state and RAM port mux. An idle port keeps its last address.
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = r_addr;
    w_data      = '0;
    w_wren      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy = 1'b1;
        w_wren = i_reset_n;   // keep the RAM untouched while reset is held
        w_addr = r_clr_addr;
        if (r_clr_addr == LAST_ADDR) w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        if (w_gnt_a) begin
          w_addr = i_a_addr;
          w_wren = i_a_we;
          w_data = i_a_we ? i_a_wdata : '0;
        end else if (w_gnt_b) begin
          w_addr = i_b_addr;
          w_wren = i_b_we;
          w_data = i_b_we ? i_b_wdata : '0;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // State, clear counter (stops at the last word) and held RAM address.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= RST_STATE;
      r_clr_addr <= '0;
      r_addr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr;
      if (r_state == S_CLEAR && r_clr_addr != LAST_ADDR)
        r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // Response pipeline: remember who issued a read this cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_owner <= REQ_A;
    end else begin
      r_rsp_vld <= (w_gnt_a | w_gnt_b) & ~w_grant_we;
      if (w_gnt_a | w_gnt_b) r_rsp_owner <= w_gnt_b ? REQ_B : REQ_A;
    end
  end

  assign o_a_ready     = w_gnt_a;
  assign o_b_ready     = w_gnt_b;
  assign o_a_rsp_valid = r_rsp_vld & (r_rsp_owner == REQ_A);
  assign o_b_rsp_valid = r_rsp_vld & (r_rsp_owner == REQ_B);
  assign o_a_rsp_data  = i_ram_q;
  assign o_b_rsp_data  = i_ram_q;
  assign o_ram_address = w_addr;
  assign o_ram_data    = w_data;
  assign o_ram_wren    = w_wren;
  assign o_busy        = w_busy;
endmodule

// File: tb/tb_ram_share_ctrl.sv
// Bench for ram_share_ctrl: clear sweep, directed vector table, randomized
// traffic against a behavioural model, reset mid-read, no-clear variant.
module tb_ram_share_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [4:0] a_addr = 0, b_addr = 0;
  logic [2:0] a_wdata = 0, b_wdata = 0;
  logic       a_ready, b_ready, a_rsp_valid, b_rsp_valid, ram_wren, busy;
  logic [2:0] a_rsp_data, b_rsp_data, ram_data, ram_q;
  logic [4:0] ram_address;

  // second instance without the clear sweep, requester B idle
  logic       d0_a_valid = 0;
  logic [2:0] d0_q = 3'b110;
  logic       d0_a_ready, d0_b_ready, d0_a_rsp_valid, d0_b_rsp_valid, d0_wren, d0_busy;
  logic [2:0] d0_a_rsp_data, d0_b_rsp_data, d0_data;
  logic [4:0] d0_address;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ram_share_ctrl dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_a_valid(a_valid), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .i_b_valid(b_valid), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_a_ready(a_ready), .o_b_ready(b_ready),
    .o_a_rsp_valid(a_rsp_valid), .o_b_rsp_valid(b_rsp_valid),
    .o_a_rsp_data(a_rsp_data), .o_b_rsp_data(b_rsp_data),
    .o_ram_address(ram_address), .o_ram_data(ram_data), .o_ram_wren(ram_wren),
    .i_ram_q(ram_q), .o_busy(busy));

  ram_share_ctrl #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_a_valid(d0_a_valid), .i_a_we(1'b0), .i_a_addr(5'd0), .i_a_wdata(3'd0),
    .i_b_valid(1'b0), .i_b_we(1'b0), .i_b_addr(5'd0), .i_b_wdata(3'd0),
    .o_a_ready(d0_a_ready), .o_b_ready(d0_b_ready),
    .o_a_rsp_valid(d0_a_rsp_valid), .o_b_rsp_valid(d0_b_rsp_valid),
    .o_a_rsp_data(d0_a_rsp_data), .o_b_rsp_data(d0_b_rsp_data),
    .o_ram_address(d0_address), .o_ram_data(d0_data), .o_ram_wren(d0_wren),
    .i_ram_q(d0_q), .o_busy(d0_busy));

  // RAM model: write on the edge, registered read address, q after the edge
  logic [2:0] tram [32];
  logic [4:0] tram_ra = 0;
  always @(posedge clk) begin
    if (ram_wren) tram[ram_address] <= ram_data;
    tram_ra <= ram_address;
  end
  assign ram_q = tram[tram_ra];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural reference: memory contents, who was granted last, pending read.
  int ref_mem [32];
  int ref_last_b = 1;
  int ref_prev_addr = 31;
  int ref_pv = 0, ref_pown_b = 0, ref_paddr = 0;
  int m_ga = 0, m_gb = 0;

  task automatic model_step(input bit do_check);
    int ga, gb, ead, ewr, edt;
    ga = (a_valid && (!b_valid || ref_last_b == 1)) ? 1 : 0;
    gb = (b_valid && (!a_valid || ref_last_b == 0)) ? 1 : 0;
    ead = ga ? int'(a_addr) : gb ? int'(b_addr) : ref_prev_addr;
    ewr = ga ? int'(a_we) : gb ? int'(b_we) : 0;
    edt = ewr ? (ga ? int'(a_wdata) : int'(b_wdata)) : 0;
    if (do_check) begin
      chk("rnd_a_ready", a_ready, ga);
      chk("rnd_b_ready", b_ready, gb);
      chk("rnd_wren", ram_wren, ewr);
      chk("rnd_addr", ram_address, ead);
      chk("rnd_data", ram_data, edt);
      chk("rnd_a_rsp_valid", a_rsp_valid, (ref_pv && !ref_pown_b) ? 1 : 0);
      chk("rnd_b_rsp_valid", b_rsp_valid, (ref_pv && ref_pown_b) ? 1 : 0);
      if (ref_pv && !ref_pown_b) chk("rnd_a_rsp_data", a_rsp_data, ref_mem[ref_paddr]);
      if (ref_pv && ref_pown_b)  chk("rnd_b_rsp_data", b_rsp_data, ref_mem[ref_paddr]);
    end
    if (ewr) ref_mem[ead] = edt;
    ref_pv = ((ga || gb) && !ewr) ? 1 : 0;
    if (ga || gb) begin ref_pown_b = gb; ref_paddr = ead; ref_last_b = gb; end
    ref_prev_addr = ead;
    m_ga = ga;
    m_gb = gb;
  endtask

  typedef struct {
    int av, awe, aa, aw, bv, bwe, ba, bw;
    int ear, ebr, ewr, ead, edt, earv, eard, ebrv, ebrd;
  } vec_t;
  vec_t tbl [14];

  initial begin
    //          av awe aa aw  bv bwe ba bw  ar br wr ad dt arv ard brv brd
    tbl[0]  = '{1, 1, 5, 5,  1, 0, 6, 0,  1, 0, 1, 5, 5, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 5, 0,  1, 0, 6, 0,  0, 1, 0, 6, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 5, 0,  0, 0, 0, 0,  1, 0, 0, 5, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 5, 0, 1, 5, 0, 0};
    tbl[4]  = '{1, 1, 1, 3,  1, 1, 2, 6,  0, 1, 1, 2, 6, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 3,  0, 0, 0, 0,  1, 0, 1, 1, 3, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 0,  1, 0, 2, 0,  0, 1, 0, 2, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 0,  1, 0, 2, 0,  1, 0, 0, 1, 0, 0, 0, 1, 6};
    tbl[9]  = '{1, 0, 1, 0,  1, 0, 2, 0,  0, 1, 0, 2, 0, 1, 3, 0, 0};
    tbl[10] = '{1, 0, 1, 0,  1, 0, 2, 0,  1, 0, 0, 1, 0, 0, 0, 1, 6};
    tbl[11] = '{1, 0, 1, 0,  1, 0, 2, 0,  0, 1, 0, 2, 0, 1, 3, 0, 0};
    tbl[12] = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0, 1, 6};
    tbl[13] = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0, 0, 0};
    for (int i = 0; i < 32; i++) begin ref_mem[i] = 0; tram[i] = 3'd7; end

    // reset values
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_a_ready", a_ready, 0);       chk("rst_b_ready", b_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0); chk("rst_b_rsp_valid", b_rsp_valid, 0);
    chk("rst_wren", ram_wren, 0);         chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);         chk("rst_busy", busy, 1);
    chk("rst_d0_busy", d0_busy, 0);       chk("rst_d0_wren", d0_wren, 0);

    // release and watch the 32-cycle sweep; requests raised mid-sweep must wait
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      d0_a_valid = (c == 0);
      if (c == 20) begin a_valid = 1; a_we = 1; a_addr = 5; a_wdata = 5; end
      if (c == 25) begin b_valid = 1; b_we = 0; b_addr = 6; b_wdata = 0; end
      #1;
      chk("clr_busy", busy, 1);
      chk("clr_wren", ram_wren, 1);
      chk("clr_addr", ram_address, c);
      chk("clr_data", ram_data, 0);
      chk("clr_a_ready", a_ready, 0);
      chk("clr_b_ready", b_ready, 0);
      if (c == 0) begin
        chk("d0_a_ready_first", d0_a_ready, 1);
        chk("d0_addr_first", d0_address, 0);
      end
      if (c == 1) begin
        chk("d0_a_rsp_valid", d0_a_rsp_valid, 1);
        chk("d0_a_rsp_data", d0_a_rsp_data, int'(d0_q));
      end
      if (c == 2) chk("d0_a_rsp_valid_once", d0_a_rsp_valid, 0);
    end

    // directed vector table, first row lands in cycle 33
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a_valid = 1'(tbl[i].av); a_we = 1'(tbl[i].awe); a_addr = 5'(tbl[i].aa); a_wdata = 3'(tbl[i].aw);
      b_valid = 1'(tbl[i].bv); b_we = 1'(tbl[i].bwe); b_addr = 5'(tbl[i].ba); b_wdata = 3'(tbl[i].bw);
      #1;
      if (i == 0) chk("first_serve_busy", busy, 0);
      chk("tbl_a_ready", a_ready, tbl[i].ear);
      chk("tbl_b_ready", b_ready, tbl[i].ebr);
      chk("tbl_wren", ram_wren, tbl[i].ewr);
      chk("tbl_addr", ram_address, tbl[i].ead);
      chk("tbl_data", ram_data, tbl[i].edt);
      chk("tbl_a_rsp_valid", a_rsp_valid, tbl[i].earv);
      chk("tbl_b_rsp_valid", b_rsp_valid, tbl[i].ebrv);
      if (tbl[i].earv != 0) chk("tbl_a_rsp_data", a_rsp_data, tbl[i].eard);
      if (tbl[i].ebrv != 0) chk("tbl_b_rsp_data", b_rsp_data, tbl[i].ebrd);
      model_step(1'b0);
    end

    // randomized traffic; each requester holds its request until accepted
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!a_valid || m_ga != 0) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom_range(0, 1));
        a_addr = 5'($urandom_range(0, 7));
        a_wdata = 3'($urandom_range(0, 7));
      end
      if (!b_valid || m_gb != 0) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_we = 1'($urandom_range(0, 1));
        b_addr = 5'($urandom_range(0, 7));
        b_wdata = 3'($urandom_range(0, 7));
      end
      #1;
      model_step(1'b1);
    end

    // reset pulsed the cycle after a read is accepted
    @(negedge clk);
    a_valid = 1; a_we = 0; a_addr = 3; b_valid = 0;
    #1 chk("mid_a_ready", a_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_rsp_valid", a_rsp_valid, 0);
    chk("mid_rst_b_rsp_valid", b_rsp_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_wren", ram_wren, 0);
    @(negedge clk);
    a_valid = 0;
    rst_n = 1'b1;
    #1;
    chk("restart_addr0", ram_address, 0);
    chk("restart_wren", ram_wren, 1);
    chk("restart_a_rsp_valid", a_rsp_valid, 0);
    @(negedge clk); #1;
    chk("restart_addr1", ram_address, 1);
    chk("restart_a_rsp_valid2", a_rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
